// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: bit-serial ADD/SUB/INC/DEC driver for a 1-bit arithmetic slice
module serial_alu_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_carry_in,
    output logic [1:0]       slice_operation,
    input  logic             slice_out,
    input  logic             slice_carry_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a_sh, r_b_sh, r_result;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_sel;
    logic             r_cy, r_carry, r_ovf, r_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_last     = r_cnt == CW'(WIDTH - 1);
    assign w_res_next = {slice_out, r_result[WIDTH-1:1]};
    assign result     = r_result;
    assign carry      = r_carry;
    assign overflow   = r_ovf;
    assign zero       = r_zero;

    // state register
    always_ff @(posedge clk)
        r_state <= !rst_n ? S_IDLE : w_next;

    // next state, handshake and slice drive; slice inputs are quiet outside SHIFT
    always_comb begin
        w_next          = r_state;
        ready           = 1'b0;
        done            = 1'b0;
        slice_a         = 1'b0;
        slice_b         = 1'b0;
        slice_carry_in  = 1'b0;
        slice_operation = 2'b00;
        case (r_state)
            S_IDLE: begin
                ready  = 1'b1;
                w_next = start ? S_SHIFT : S_IDLE;
            end
            S_SHIFT: begin
                slice_a         = r_a_sh[0];
                slice_b         = r_b_sh[0];
                slice_carry_in  = r_cy;
                slice_operation = r_sel;
                w_next          = w_last ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // datapath: operand shifters, carry chain register, result collection and flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_cy     <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            // select: ADD=10 SUB=01 INC=11 DEC=00; carry-in is 1 for SUB and INC
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_sel    <= {~op[0], op[0] ^ op[1]};
            r_cy     <= op[0] ^ op[1];
            r_cnt    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_result <= w_res_next;
            r_cy     <= slice_carry_out;
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                // r_cy here is the carry into the MSB; XOR with carry out gives signed overflow
                r_carry <= slice_carry_out;
                r_ovf   <= r_cy ^ slice_carry_out;
                r_zero  <= w_res_next == '0;
            end
        end
    end
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb_serial_alu_sequencer: randomized and directed check of the serial ALU sequencer with a behavioural slice
module tb_serial_alu_sequencer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0;
    logic         ready, done, carry, overflow, zero;
    logic [W-1:0] result;
    logic         slice_a, slice_b, slice_carry_in, slice_out, slice_carry_out;
    logic [1:0]   slice_operation;
    logic         w_bsel;
    int           n_tests = 0;
    int           n_fail = 0;
    int           done_cnt = 0;

    always #5 clk = ~clk;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .done(done), .result(result), .carry(carry),
        .overflow(overflow), .zero(zero), .slice_a(slice_a), .slice_b(slice_b),
        .slice_carry_in(slice_carry_in), .slice_operation(slice_operation),
        .slice_out(slice_out), .slice_carry_out(slice_carry_out)
    );

    // 1-bit arithmetic slice
    assign w_bsel = slice_operation == 2'b00 ? 1'b1 :
                    slice_operation == 2'b01 ? ~slice_b :
                    slice_operation == 2'b10 ? slice_b : 1'b0;
    assign slice_out       = slice_a ^ w_bsel ^ slice_carry_in;
    assign slice_carry_out = (slice_a & w_bsel) | (slice_a & slice_carry_in) | (w_bsel & slice_carry_in);

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        return v[W-1] ? longint'(v) - (longint'(1) << W) : longint'(v);
    endfunction

    // reference: {carry, overflow, result} from plain integer arithmetic
    function automatic logic [W+1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint u, s;
        logic   c, v;
        case (o)
            2'd0: begin u = longint'(x) + longint'(y); s = sx(x) + sx(y); c = u >= (longint'(1) << W); end
            2'd1: begin u = longint'(x) - longint'(y); s = sx(x) - sx(y); c = x >= y; end
            2'd2: begin u = longint'(x) + 1; s = sx(x) + 1; c = x == {W{1'b1}}; end
            default: begin u = longint'(x) - 1; s = sx(x) - 1; c = x != 0; end
        endcase
        v = s > ((longint'(1) << (W - 1)) - 1) || s < -(longint'(1) << (W - 1));
        return {c, v, W'(u)};
    endfunction

    function automatic logic [1:0] exp_sel(input logic [1:0] o);
        case (o)
            2'd0: return 2'b10;
            2'd1: return 2'b01;
            2'd2: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // starts at a negedge, ends at the negedge after DONE with the DUT back in IDLE
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W+1:0] m;
        int           k;
        m = model(o, x, y);
        k = 0;
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", 32'(ready), 32'd1);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~y;
        for (int i = 0; i < W; i++) begin
            check("slice_a", 32'(slice_a), 32'(x[i]));
            check("slice_b", 32'(slice_b), 32'(y[i]));
            check("slice_op", 32'(slice_operation), 32'(exp_sel(o)));
            if (i == 0) check("slice_cin0", 32'(slice_carry_in), 32'(o == 2'd1 || o == 2'd2));
            check("busy", 32'({ready, done}), 32'd0);
            @(negedge clk);
        end
        check("done_latency", 32'(done), 32'd1);
        check("result", 32'(result), 32'(m[W-1:0]));
        check("carry", 32'(carry), 32'(m[W+1]));
        check("overflow", 32'(overflow), 32'(m[W]));
        check("zero", 32'(zero), 32'(m[W-1:0] == 0));
        @(negedge clk);
        check("done_pulse", 32'({done, ready}), 32'b01);
        check("slice_idle", 32'({slice_a, slice_b, slice_carry_in, slice_operation}), 32'd0);
        check("result_hold", 32'(result), 32'(m[W-1:0]));
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'({ready, done, carry, overflow, zero}), 32'b10000);
        check("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'd0, 4'b0111, 4'b1001);
        check("add_wrap", 32'({result, carry, zero, overflow}), 32'b0000_110);
        run_op(2'd0, 4'b0111, 4'b0001);
        check("add_ovf", 32'({result, carry, overflow, zero}), 32'b1000_010);
        run_op(2'd1, 4'b0011, 4'b0101);
        check("sub_neg", 32'({result, carry, overflow}), 32'b1110_00);
        run_op(2'd2, 4'b1111, 4'b0110);
        check("inc_wrap", 32'({result, carry, zero}), 32'b0000_11);
        run_op(2'd3, 4'b0000, 4'b1010);
        check("dec_wrap", 32'({result, carry}), 32'b1111_0);
        run_op(2'd3, 4'b1000, 4'b0000);
        check("dec_ovf", 32'({result, overflow}), 32'b0111_1);
        run_op(2'd1, 4'b0110, 4'b0011);
        check("sub_mon", 32'(result), 32'b0011);

        // start while busy is ignored
        d0 = done_cnt;
        start = 1'b1; op = 2'd0; a = 4'b0011; b = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        op = 2'd1; a = 4'b1111; b = 4'b0001;
        @(negedge clk);
        a = 4'b1010; b = 4'b0101;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        check("ign_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("ign_result", 32'(result), 32'b0111);

        // reset on 2nd SHIFT cycle aborts without done
        d0 = done_cnt;
        start = 1'b1; op = 2'd0; a = 4'b0101; b = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_state", 32'({ready, done, carry, overflow, zero}), 32'b10000);
        check("abort_result", 32'(result), 32'd0);
        check("abort_slice", 32'({slice_a, slice_b, slice_carry_in, slice_operation}), 32'd0);
        repeat (W + 2) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(2'd0, 4'b0010, 4'b0011);
        check("post_rst_add", 32'(result), 32'b0101);

        for (int t = 0; t < 40; t++)
            run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
